// File: rtl/ffram_march_bist.sv
// March C- BIST controller for a flip-flop RAM with combinational read data.
// Runs six march elements and records pass/fail plus the first failing address and element.
module ffram_march_bist #(
  parameter int ADDR_W = 1,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [2:0]        ELEM_LAST = 3'd5;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        elem;

  logic              active;
  logic              down;
  logic              elem_end;
  logic [ADDR_W-1:0] addr_step;
  logic [DATA_W-1:0] rd_exp;
  logic [DATA_W-1:0] wr_val;
  logic              mismatch;

  // Elements 3..5 walk the address space downward.
  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    active    = (state == S_RD) || (state == S_WR);
    down      = (elem >= 3'd3);
    elem_end  = down ? (addr == '0) : (addr == ADDR_LAST);
    addr_step = down ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
    rd_exp    = ((elem == 3'd2) || (elem == 3'd4)) ? '1 : '0;
    wr_val    = ((elem == 3'd1) || (elem == 3'd3)) ? '1 : '0;
    mismatch  = (mem_dout != rd_exp);
  end

  assign busy     = active;
  assign mem_addr = active ? addr : '0;
  assign mem_wen  = (state == S_WR);
  assign mem_din  = (state == S_WR) ? wr_val : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      elem      <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_WR;
            addr      <= '0;
            elem      <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
          end
        end
        S_WR: begin
          if (elem_end) begin
            // Next element always opens with a read; elements 3..5 start at the top.
            state <= S_RD;
            elem  <= elem + 3'd1;
            addr  <= (elem >= 3'd2) ? ADDR_LAST : '0;
          end else begin
            state <= (elem == 3'd0) ? S_WR : S_RD;
            addr  <= addr_step;
          end
        end
        S_RD: begin
          if (mismatch) begin
            state     <= S_FIN;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_addr <= addr;
            fail_elem <= elem;
          end else if (elem == ELEM_LAST) begin
            if (elem_end) begin
              state <= S_IDLE;
              done  <= 1'b1;
              pass  <= 1'b1;
              addr  <= '0;
              elem  <= '0;
            end else begin
              addr <= addr_step;
            end
          end else begin
            state <= S_WR;
          end
        end
        default: begin
          state <= S_IDLE;
          addr  <= '0;
          elem  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ffram_march_bist.sv
// Randomized bench for ffram_march_bist: a faulty-RAM harness plus an array-level March C- model.
module tb_ffram_march_bist;

  localparam int AW = 2;
  localparam int DW = 2;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_wen;
  logic [DW-1:0] mem_dout;
  logic          busy, done, pass, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;

  ffram_march_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(mem_dout),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem)
  );

  always #5 clk = ~clk;

  // Fault kinds: 0 none, 1 word stuck-at-0, 2 word stuck-at-1, 3 address bit stuck at 0.
  int fault_kind = 0;
  int fault_word = 0;
  int fault_bit  = 0;

  logic [DW-1:0] ram [N];
  logic [DW-1:0] ram_init [N];
  logic          ram_load = 1'b0;
  logic [AW-1:0] ea;

  always_comb begin
    ea = mem_addr;
    if (fault_kind == 3) ea[fault_bit] = 1'b0;
    mem_dout = ram[ea];
    if (fault_kind == 1 && int'(ea) == fault_word) mem_dout = '0;
    if (fault_kind == 2 && int'(ea) == fault_word) mem_dout = '1;
  end

  always @(posedge clk) begin
    if (ram_load) ram <= ram_init;
    else if (mem_wen) ram[ea] <= mem_din;
  end

  // Reference model: expected op trace and outcome, computed from the march table.
  typedef struct {
    bit            wr;
    int            elem;
    int            addr;
    logic [DW-1:0] val;
  } op_t;

  op_t exp_ops[$];
  bit  exp_fail;
  int  exp_faddr, exp_felem;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_ea(int a);
    if (fault_kind == 3) return a & ~(1 << fault_bit);
    return a;
  endfunction

  function automatic logic [DW-1:0] model_rd(logic [DW-1:0] d, int e);
    if (fault_kind == 1 && e == fault_word) return '0;
    if (fault_kind == 2 && e == fault_word) return '1;
    return d;
  endfunction

  task automatic build_model();
    logic [DW-1:0] m [N];
    logic [DW-1:0] expv, got;
    int a;
    op_t op;
    m = ram_init;
    exp_ops.delete();
    exp_fail  = 0;
    exp_faddr = 0;
    exp_felem = 0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < N; k++) begin
        a = (e >= 3) ? (N - 1 - k) : k;
        if (e > 0) begin
          expv = (e == 2 || e == 4) ? '1 : '0;
          op = '{wr: 1'b0, elem: e, addr: a, val: expv};
          exp_ops.push_back(op);
          got = model_rd(m[model_ea(a)], model_ea(a));
          if (got !== expv) begin
            exp_fail  = 1;
            exp_faddr = a;
            exp_felem = e;
            return;
          end
        end
        if (e < 5) begin
          op = '{wr: 1'b1, elem: e, addr: a, val: (e == 1 || e == 3) ? '1 : '0};
          exp_ops.push_back(op);
          m[model_ea(a)] = op.val;
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_faddr"}, fail_addr, 0);
    check({tag, "_felem"}, fail_elem, 0);
    check({tag, "_wen"}, mem_wen, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_din"}, mem_din, 0);
  endtask

  // Called at a negedge with the DUT idle; reset_at < 0 means no mid-run reset.
  task automatic do_run(input int reset_at, input bit random_starts);
    int wen_count;
    for (int i = 0; i < N; i++) ram_init[i] = DW'($urandom);
    ram_load = 1'b1;
    @(negedge clk);
    ram_load = 1'b0;
    build_model();
    start = 1'b1;
    @(negedge clk);
    wen_count = 0;
    for (int i = 0; i < exp_ops.size(); i++) begin
      if (i == 0) begin
        check("clr_done", done, 0);
        check("clr_pass", pass, 0);
        check("clr_fail", fail, 0);
        check("clr_faddr", fail_addr, 0);
        check("clr_felem", fail_elem, 0);
      end
      check("op_busy", busy, 1);
      check("op_wen", mem_wen, exp_ops[i].wr);
      check("op_addr", mem_addr, exp_ops[i].addr);
      check("op_din", mem_din, exp_ops[i].wr ? exp_ops[i].val : '0);
      if (mem_wen) wen_count++;
      if (i == reset_at) begin
        reset = 1'b1;
        start = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("postrst");
        return;
      end
      start = random_starts ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("end_busy", busy, 0);
    check("end_done", done, 1);
    check("end_pass", pass, !exp_fail);
    check("end_fail", fail, exp_fail);
    check("end_faddr", fail_addr, exp_faddr);
    check("end_felem", fail_elem, exp_felem);
    check("end_wen", mem_wen, 0);
    if (!exp_fail) check("wen_pulses", wen_count, 5 * N);
    repeat (2) @(negedge clk);
    check("hold_busy", busy, 0);
    check("hold_done", done, 1);
    check("hold_pass", pass, !exp_fail);
    check("hold_fail", fail, exp_fail);
    check("hold_wen", mem_wen, 0);
    check("hold_addr", mem_addr, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed: clean run, stuck word, stuck address bit, fail then clean rerun, mid-run reset.
    fault_kind = 0;
    do_run(-1, 1'b0);
    fault_kind = 1; fault_word = 1;
    do_run(-1, 1'b0);
    fault_kind = 3; fault_bit = 0;
    do_run(-1, 1'b1);
    fault_kind = 0;
    do_run(-1, 1'b1);
    do_run(6, 1'b0);
    do_run(-1, 1'b0);

    for (int r = 0; r < 40; r++) begin
      fault_kind = $urandom_range(0, 3);
      fault_word = $urandom_range(0, N - 1);
      fault_bit  = $urandom_range(0, AW - 1);
      do_run(($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1,
             1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
